// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard, forwarding and data-memory wait controller for a 5-stage RISC-V pipeline
//
// Purpose:
//   Generates EX-stage forwarding selects, load-use stalls and branch/jump flushes.
//   Runs a data-memory wait FSM that freezes F/D/E/M and bubbles MEM/WB while a
//   multi-cycle data-memory access is outstanding.
//
// Optional feature macro: HAZARD_PERF_CNT_EN (adds o_stallCycles / o_flushCount).
//
// Parameters:
//   MEM_TIMEOUT  maximum wait cycles for i_memReadyM before timeout (MEM_TIMEOUT < 2**CNT_W)
//   CNT_W        wait counter width
//   PERF_W       performance counter width
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   i_Rs1D, i_Rs2D                    source registers in D
//   i_Rs1E, i_Rs2E                    source registers in E
//   i_RdE, i_RdM, i_RdW               destination registers in E/M/W
//   i_resultSrcE                      result select in E (2'b01 = load)
//   i_regWriteM, i_regWriteW          register-write enables in M/W
//   i_PCSrcE                          taken branch/jump resolved in E
//   i_memAccessM, i_memReadyM         data-memory access present / completes this cycle
//   o_forwardAE, o_forwardBE          EX operand select: 00 RF, 01 W result, 10 M ALU result
//   o_stallF/D/E/M                    hold PC / pipeline registers
//   o_flushD/E/W                      clear IF/ID, ID/EX, MEM/WB to a bubble
//   o_memBusy                         FSM not idle, or waiting this cycle
//   o_timeoutErr                      sticky timeout flag
//   o_stallCycles, o_flushCount       saturating perf counters (HAZARD_PERF_CNT_EN only)

module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        i_Rs1D,
    input  logic [4:0]        i_Rs2D,
    input  logic [4:0]        i_Rs1E,
    input  logic [4:0]        i_Rs2E,
    input  logic [4:0]        i_RdE,
    input  logic [4:0]        i_RdM,
    input  logic [4:0]        i_RdW,
    input  logic [1:0]        i_resultSrcE,
    input  logic              i_regWriteM,
    input  logic              i_regWriteW,
    input  logic              i_PCSrcE,
    input  logic              i_memAccessM,
    input  logic              i_memReadyM,
    output logic [1:0]        o_forwardAE,
    output logic [1:0]        o_forwardBE,
    output logic              o_stallF,
    output logic              o_stallD,
    output logic              o_stallE,
    output logic              o_stallM,
    output logic              o_flushD,
    output logic              o_flushE,
    output logic              o_flushW,
    output logic              o_memBusy,
    output logic              o_timeoutErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] o_stallCycles,
    output logic [PERF_W-1:0] o_flushCount
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(MEM_TIMEOUT);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_waitCnt;
    logic             r_timeoutErr;

    logic       w_lwStall;
    logic       w_memStall;
    logic [1:0] w_fwdA;
    logic [1:0] w_fwdB;

    // M stage has priority: it holds the younger result for the same register.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w
    );
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    always_comb begin
        w_fwdA = fwd_sel(i_Rs1E, i_regWriteM, i_RdM, i_regWriteW, i_RdW);
        w_fwdB = fwd_sel(i_Rs2E, i_regWriteM, i_RdM, i_regWriteW, i_RdW);
    end

    always_comb begin
        w_lwStall = (i_resultSrcE == 2'b01) && (i_RdE != 5'd0) &&
                    ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
    end

    // In WAIT the stall drops in the same cycle memReadyM rises, so the
    // access completes without an extra bubble.
    always_comb begin
        w_memStall = 1'b0;
        case (r_state)
            S_IDLE:  w_memStall = i_memAccessM && !i_memReadyM;
            S_WAIT:  w_memStall = !i_memReadyM;
            S_ERR:   w_memStall = 1'b1;
            default: w_memStall = 1'b0;
        endcase
    end

    // All control outputs are forced quiet while reset is held, independent
    // of the combinational inputs.
    always_comb begin
        o_forwardAE  = 2'b00;
        o_forwardBE  = 2'b00;
        o_stallF     = 1'b0;
        o_stallD     = 1'b0;
        o_stallE     = 1'b0;
        o_stallM     = 1'b0;
        o_flushD     = 1'b0;
        o_flushE     = 1'b0;
        o_flushW     = 1'b0;
        o_memBusy    = 1'b0;
        o_timeoutErr = r_timeoutErr;
        if (!rst) begin
            o_forwardAE = w_fwdA;
            o_forwardBE = w_fwdB;
            o_memBusy   = (r_state != S_IDLE) || w_memStall;
            if (w_memStall) begin
                // Frozen stages are never flushed; load-use and branch are
                // re-evaluated on release since D/E contents are unchanged.
                o_stallF = 1'b1;
                o_stallD = 1'b1;
                o_stallE = 1'b1;
                o_stallM = 1'b1;
                o_flushW = 1'b1;
            end else begin
                o_stallF = w_lwStall;
                o_stallD = w_lwStall;
                o_flushD = i_PCSrcE;
                o_flushE = w_lwStall || i_PCSrcE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_waitCnt    <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_memAccessM && !i_memReadyM) begin
                        r_state   <= S_WAIT;
                        r_waitCnt <= CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (i_memReadyM) begin
                        r_state   <= S_IDLE;
                        r_waitCnt <= '0;
                    end else if (r_waitCnt == L_TIMEOUT) begin
                        r_state      <= S_ERR;
                        r_timeoutErr <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + CNT_W'(1);
                    end
                end
                S_ERR: begin
                    // Held until reset; stalls remain asserted.
                    r_state <= S_ERR;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_waitCnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] r_stallCycles;
    logic [PERF_W-1:0] r_flushCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if (o_stallF && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + PERF_W'(1);
            end
            if (o_flushE && (r_flushCount != '1)) begin
                r_flushCount <= r_flushCount + PERF_W'(1);
            end
        end
    end

    assign o_stallCycles = r_stallCycles;
    assign o_flushCount  = r_flushCount;
`endif

endmodule
